// File: rtl/data_memory_controller.sv
// rtl/data_memory_controller.sv - block-granular backing memory with fixed multi-cycle latency
module data_memory_controller #(
    parameter int BLOCK_ADDR_WIDTH = 28,
    parameter int DEPTH            = 256,
    parameter int LATENCY          = 5
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        mem_read,
    input  logic                        mem_write,
    input  logic [BLOCK_ADDR_WIDTH-1:0] mem_address,
    input  logic [127:0]                mem_writedata,
    output logic [127:0]                mem_readdata,
    output logic                        mem_busywait
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                      state;
    logic [3:0]                  counter;
    logic [BLOCK_ADDR_WIDTH-1:0] addr_q;
    logic [127:0]                wdata_q;
    logic                        write_q;
    logic [127:0]                array [DEPTH];
    logic [IDX_W-1:0]            idx;
    logic                        complete;

    assign idx      = IDX_W'(addr_q % BLOCK_ADDR_WIDTH'(DEPTH));
    assign complete = (state == BUSY) && (counter == 4'd0);

    // Control and read path; the array itself is deliberately outside the reset domain.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            counter      <= 4'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            mem_readdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        addr_q  <= mem_address;
                        wdata_q <= mem_writedata;
                        write_q <= mem_write;
                        counter <= 4'(LATENCY - 1);
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (counter != 4'd0) begin
                        counter <= counter - 4'd1;
                    end else begin
                        if (!write_q) begin
                            mem_readdata <= array[idx];
                        end
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (complete && write_q) begin
            array[idx] <= wdata_q;
        end
    end

    // Busywait rises combinationally with a new request so the cache stalls that same cycle.
    always_comb begin
        mem_busywait = 1'b0;
        case (state)
            IDLE:    mem_busywait = reset && (mem_read || mem_write);
            BUSY:    mem_busywait = 1'b1;
            DONE:    mem_busywait = 1'b0;
            default: mem_busywait = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_data_memory_controller.sv
// tb/tb_data_memory_controller.sv - scoreboard bench for data_memory_controller
module tb_data_memory_controller;

    logic         clock;
    logic         reset;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_address;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    int tests_run = 0;
    int tests_failed = 0;

    logic [127:0] model [256];
    logic [127:0] sb [$];

    data_memory_controller #(
        .BLOCK_ADDR_WIDTH(28),
        .DEPTH(256),
        .LATENCY(5)
    ) dut (
        .clock(clock),
        .reset(reset),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_address(mem_address),
        .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata),
        .mem_busywait(mem_busywait)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full access: request at a negedge, watch every cycle until busywait releases.
    task automatic access(input logic rd, input logic wr, input logic [27:0] addr,
                          input logic [127:0] data, input bit scramble, input bit hold);
        logic [127:0] prev;
        logic [127:0] exp;
        int edges;
        @(negedge clock);
        mem_read      = rd;
        mem_write     = wr;
        mem_address   = addr;
        mem_writedata = data;
        if (wr) model[addr[7:0]] = data;
        else    sb.push_back(model[addr[7:0]]);
        #1 check("busy_on_request", mem_busywait, 1);
        prev  = mem_readdata;
        edges = 0;
        do begin
            @(posedge clock);
            edges++;
            @(negedge clock);
            if (mem_busywait) begin
                check("rdata_held_busy", mem_readdata, prev);
                if (scramble) begin
                    mem_address   = 28'($urandom);
                    mem_writedata = {$urandom, $urandom, $urandom, $urandom};
                end
            end
        end while (mem_busywait && edges < 20);
        check("latency_edges", edges, 6);
        if (!hold) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
        if (rd && !wr) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                exp = sb.pop_front();
                check("read_data", mem_readdata, exp);
            end
        end else begin
            check("rdata_unchanged_write", mem_readdata, prev);
        end
    endtask

    initial begin
        reset         = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        #12;
        check("reset_busywait", mem_busywait, 0);
        check("reset_readdata", mem_readdata, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("idle_busywait", mem_busywait, 0);

        // Write then read back
        access(0, 1, 28'h0000010, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 0, 0);
        access(1, 0, 28'h0000010, '0, 0, 0);

        // Operands scrambled during BUSY must be ignored
        access(0, 1, 28'h0000020, 128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0, 1, 0);
        access(1, 0, 28'h0000020, '0, 1, 0);
        access(1, 0, 28'h0000010, '0, 1, 0);

        // Held read through DONE: second read accepted only at the following IDLE edge
        access(1, 0, 28'h0000020, '0, 0, 1);
        access(1, 0, 28'h0000010, '0, 0, 0);
        check("sb_drained", sb.size(), 0);

        // Aliasing modulo DEPTH, and simultaneous read+write treated as write
        access(0, 1, 28'h0000005, {32{4'hA}}, 0, 0);
        model[8'h05] = {32{4'hA}};
        access(1, 0, 28'h0000105, '0, 0, 0);
        access(1, 1, 28'h0000007, 128'h7777_0000_7777_0000_7777_0000_7777_0000, 0, 0);
        access(1, 0, 28'h0000007, '0, 0, 0);

        // Mid-sim reset with a request pending
        @(negedge clock);
        mem_read    = 1'b1;
        mem_address = 28'h0000010;
        #2 reset = 1'b0;
        #1;
        check("async_reset_busywait", mem_busywait, 0);
        check("async_reset_readdata", mem_readdata, 0);
        @(negedge clock);
        mem_read = 1'b0;
        reset    = 1'b1;
        @(negedge clock);
        check("post_reset_idle", mem_busywait, 0);

        // Reset abandons an in-flight write
        access(0, 1, 28'h0000003, 128'h3333_4444_5555_6666_7777_8888_9999_AAAA, 0, 0);
        @(negedge clock);
        mem_write     = 1'b1;
        mem_address   = 28'h0000003;
        mem_writedata = {128{1'b1}};
        @(posedge clock);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        #1 check("midwrite_reset_busywait", mem_busywait, 0);
        check("midwrite_reset_readdata", mem_readdata, 0);
        @(negedge clock);
        mem_write = 1'b0;
        reset     = 1'b1;
        access(1, 0, 28'h0000003, '0, 0, 0);
        check("sb_final_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
